// File: rtl/fib_stream_checker_pkg.sv
// -----------------------------------------------------------------------------
// fib_chk_pkg
// Shared types and constants for the Fibonacci stream checker.
//   state_t          : checker FSM states (HUNT, ACQ, CONFIRM, LOCKED)
//   SAMPLE_W         : sample width of the generator stream
//   SEED_A / SEED_B  : generator reset state (a,b)
// -----------------------------------------------------------------------------
package fib_chk_pkg;

   localparam int SAMPLE_W = 8;

   localparam logic [SAMPLE_W-1:0] SEED_A = 8'h00;
   localparam logic [SAMPLE_W-1:0] SEED_B = 8'h01;

   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      ACQ     = 2'd1,
      CONFIRM = 2'd2,
      LOCKED  = 2'd3
   } state_t;

endpackage

// File: rtl/fib_stream_checker_if.sv
// -----------------------------------------------------------------------------
// fib_stream_checker_if
// Link between the generator side (master) and the checker (slave).
//   __in0      step bit that produced this beat's sample
//   __in1      observed sample
//   __in2      beat valid
//   __out0     expected sample for the most recently accepted beat
//   __out1     locked flag
//   __out2     saturating mismatch count (ERR_W bits)
//   __out3     mismatch pulse for the most recently accepted beat
//   dbg_state  checker FSM state, for observation only
//
// Handshake: valid-only. A beat is accepted on every rising clk edge where
// __in2 is 1; there is no ready signal and the checker never stalls, so the
// master may present a new beat every cycle.
// -----------------------------------------------------------------------------
interface fib_stream_checker_if
   import fib_chk_pkg::*;
#(
   parameter int ERR_W = 16
);

   logic                __in0;
   logic [SAMPLE_W-1:0] __in1;
   logic                __in2;
   logic [SAMPLE_W-1:0] __out0;
   logic                __out1;
   logic [ERR_W-1:0]    __out2;
   logic                __out3;
   state_t              dbg_state;

   modport master (
      output __in0, __in1, __in2,
      input  __out0, __out1, __out2, __out3, dbg_state
   );

   modport slave (
      input  __in0, __in1, __in2,
      output __out0, __out1, __out2, __out3, dbg_state
   );

endinterface

// File: rtl/fib_stream_checker_model_step.sv
// -----------------------------------------------------------------------------
// fib_model_step
// One combinational step of the generator model.
//   a, b   current model state
//   step   1: advance to (b, a+b mod 256); 0: hold
//   na, nb next model state
//   exp    sample the generator emits for this beat (post-update a)
// -----------------------------------------------------------------------------
module fib_model_step
   import fib_chk_pkg::*;
(
   input  logic [SAMPLE_W-1:0] a,
   input  logic [SAMPLE_W-1:0] b,
   input  logic                step,
   output logic [SAMPLE_W-1:0] na,
   output logic [SAMPLE_W-1:0] nb,
   output logic [SAMPLE_W-1:0] exp
);

   always_comb begin
      na  = a;
      nb  = b;
      exp = a;
      if (step) begin
         na  = b;
         nb  = a + b;   // carry discarded: the generator wraps mod 256
         exp = b;
      end
   end

endmodule

// File: rtl/fib_stream_checker.sv
// -----------------------------------------------------------------------------
// fib_stream_checker
// Sink-side checker for the step-driven 8-bit Fibonacci sample stream.
// Rebuilds the generator state (a,b) from the observed samples, locks onto
// the stream and then flags every beat that disagrees with the model.
//
// Ports:
//   clk   clock
//   rst   synchronous reset, active-high
//   bus   fib_stream_checker_if.slave (beat inputs, result outputs, dbg_state)
//
// Parameters:
//   LOCK_COUNT  consecutive CONFIRM matches needed to enter LOCKED (1..15)
//   MISS_LIMIT  consecutive LOCKED mismatches that force HUNT (1..15)
//   ERR_W       width of the saturating error counter
//
// Build option:
//   FIB_CHK_SEED_EN  reset straight into LOCKED with the generator seed
//                    (a,b)=(SEED_A,SEED_B), for a generator that leaves
//                    reset on the same cycle.
// -----------------------------------------------------------------------------
module fib_stream_checker
   import fib_chk_pkg::*;
#(
   parameter int unsigned LOCK_COUNT = 4,
   parameter int unsigned MISS_LIMIT = 3,
   parameter int unsigned ERR_W      = 16
)(
   input  logic                  clk,
   input  logic                  rst,
   fib_stream_checker_if.slave   bus
);

   localparam logic [1:0] ST_HUNT    = 2'(HUNT);
   localparam logic [1:0] ST_ACQ     = 2'(ACQ);
   localparam logic [1:0] ST_CONFIRM = 2'(CONFIRM);
   localparam logic [1:0] ST_LOCKED  = 2'(LOCKED);

   // Counters compare against "limit - 1" so the transition happens on the
   // beat that brings the count up to the limit.
   localparam logic [3:0] LOCK_LAST = 4'(LOCK_COUNT - 1);
   localparam logic [3:0] MISS_LAST = 4'(MISS_LIMIT - 1);
   localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

   logic [1:0]          state_q;
   logic [SAMPLE_W-1:0] a_q;
   logic [SAMPLE_W-1:0] b_q;
   logic [SAMPLE_W-1:0] prev_q;
   logic [3:0]          match_q;
   logic [3:0]          miss_q;
   logic [ERR_W-1:0]    err_q;
   logic [SAMPLE_W-1:0] out0_q;
   logic                out1_q;
   logic                out3_q;

   logic [SAMPLE_W-1:0] na;
   logic [SAMPLE_W-1:0] nb;
   logic [SAMPLE_W-1:0] exp_s;
   logic                hit;
   logic [ERR_W-1:0]    err_next;

   fib_model_step u_step (
      .a    (a_q),
      .b    (b_q),
      .step (bus.__in0),
      .na   (na),
      .nb   (nb),
      .exp  (exp_s)
   );

   assign hit      = (exp_s == bus.__in1);
   assign err_next = (&err_q) ? err_q : (err_q + ERR_ONE);

   always_ff @(posedge clk) begin
      if (rst) begin
`ifdef FIB_CHK_SEED_EN
         state_q <= ST_LOCKED;
         a_q     <= SEED_A;
         b_q     <= SEED_B;
         out1_q  <= 1'b1;
`else
         state_q <= ST_HUNT;
         a_q     <= '0;
         b_q     <= '0;
         out1_q  <= 1'b0;
`endif
         prev_q  <= '0;
         match_q <= '0;
         miss_q  <= '0;
         err_q   <= '0;
         out0_q  <= '0;
         out3_q  <= 1'b0;
      end else begin
         out3_q <= 1'b0;
         if (bus.__in2) begin
            case (state_q)
               ST_HUNT: begin
                  prev_q  <= bus.__in1;
                  out0_q  <= bus.__in1;
                  state_q <= ST_ACQ;
               end
               ST_ACQ: begin
                  out0_q <= bus.__in1;
                  if (bus.__in0) begin
                     // Two consecutive samples of a stepping generator are
                     // its (a,b) pair minus one step: rebuild b from both.
                     a_q     <= bus.__in1;
                     b_q     <= prev_q + bus.__in1;
                     match_q <= '0;
                     state_q <= ST_CONFIRM;
                  end else begin
                     prev_q <= bus.__in1;
                  end
               end
               ST_CONFIRM: begin
                  a_q    <= na;
                  b_q    <= nb;
                  out0_q <= exp_s;
                  if (hit) begin
                     match_q <= match_q + 4'd1;
                     if (match_q == LOCK_LAST) begin
                        state_q <= ST_LOCKED;
                        out1_q  <= 1'b1;
                        miss_q  <= '0;
                     end
                  end else begin
                     out3_q  <= 1'b1;
                     err_q   <= err_next;
                     state_q <= ST_HUNT;
                  end
               end
               default: begin // ST_LOCKED
                  // The step bit is trusted, so the model advances even on
                  // a bad sample; a single glitch does not lose phase.
                  a_q    <= na;
                  b_q    <= nb;
                  out0_q <= exp_s;
                  if (hit) begin
                     miss_q <= '0;
                  end else begin
                     out3_q <= 1'b1;
                     err_q  <= err_next;
                     if (miss_q == MISS_LAST) begin
                        miss_q  <= '0;
                        out1_q  <= 1'b0;
                        state_q <= ST_HUNT;
                     end else begin
                        miss_q <= miss_q + 4'd1;
                     end
                  end
               end
            endcase
         end
      end
   end

   assign bus.__out0    = out0_q;
   assign bus.__out1    = out1_q;
   assign bus.__out2    = err_q;
   assign bus.__out3    = out3_q;
   assign bus.dbg_state = state_t'(state_q);

endmodule
